demux1_2_reg: RTL

Registered 1-to-2 demultiplexer for the 32-bit MIPS32 datapath. It steers a single valid/ready word stream into one of two destinations, such as the write-back path and the store path. Each output has a one-entry holding register and a 16-bit delivered-word counter. It is the fan-out counterpart to the 32-bit 2:1 select used on the operand side.

---
 rtl/demux1_2_reg.sv | 83 ++++++++
 1 files changed

// File: rtl/demux1_2_reg.sv
// Registered 1:2 demux: one valid/ready word stream steered by in_sel into one of two
// single-entry holding registers with wrap-around delivery counters; 1-cycle latency, per-port backpressure only.
module demux1_2_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z0_data,
  output logic             z0_valid,
  input  logic             z0_ready,
  output logic [WIDTH-1:0] z1_data,
  output logic             z1_valid,
  input  logic             z1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state0;
  state_t state1;

  logic room0;
  logic room1;
  logic load0;
  logic load1;
  logic deliver0;
  logic deliver1;

  // A port can take a word if it is empty or is handing its word off this cycle.
  assign room0    = (state0 == EMPTY) || z0_ready;
  assign room1    = (state1 == EMPTY) || z1_ready;
  assign in_ready = in_sel ? room1 : room0;

  assign load0    = in_valid && room0 && !in_sel;
  assign load1    = in_valid && room1 &&  in_sel;
  assign deliver0 = (state0 == FULL) && z0_ready;
  assign deliver1 = (state1 == FULL) && z1_ready;

  assign z0_valid = (state0 == FULL);
  assign z1_valid = (state1 == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state0  <= EMPTY;
      z0_data <= '0;
      cnt0    <= '0;
    end else begin
      if (state0 == EMPTY) begin
        if (load0) state0 <= FULL;
      end else begin
        if (deliver0 && !load0) state0 <= EMPTY;
      end
      if (load0)    z0_data <= in_data;
      if (deliver0) cnt0    <= cnt0 + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state1  <= EMPTY;
      z1_data <= '0;
      cnt1    <= '0;
    end else begin
      if (state1 == EMPTY) begin
        if (load1) state1 <= FULL;
      end else begin
        if (deliver1 && !load1) state1 <= EMPTY;
      end
      if (load1)    z1_data <= in_data;
      if (deliver1) cnt1    <= cnt1 + CNT_W'(1);
    end
  end

endmodule
